// File: rtl/menu_key_sequence_decoder.sv
// Menu-then-key sequence decoder for the hood front panel.
// A menu-button rising edge arms the decoder, but only while the mode FSM is in
// ARM_MODE. The first function key seen after menu is released becomes a held
// request with a valid/ack handshake. An idle armed window expires after
// TIMEOUT_CYCLES. Leaving ARM_MODE aborts everything.
// All outputs are registered, so no input reaches an output combinationally.
module menu_key_sequence_decoder #(
  parameter int                NUM_KEYS       = 4,
  parameter int                MODE_W         = 3,
  parameter logic [MODE_W-1:0] ARM_MODE       = MODE_W'(0),
  parameter int                TIMEOUT_CYCLES = 1000,
  localparam int               IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [MODE_W-1:0]   current_mode,
  input  logic                menu_signal,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                req_ack,
  output logic                req_valid,
  output logic [NUM_KEYS-1:0] req_onehot,
  output logic [IDX_W-1:0]    req_index,
  output logic                armed,
  output logic                timeout_pulse
);

  // A zero timeout disables expiry entirely. The timer then keeps a 1-bit stub.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int TIMER_W    = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The armed window counts RELOAD down to 0 inclusive.
  // That gives exactly TIMEOUT_CYCLES armed cycles.
  localparam logic [TIMER_W-1:0] RELOAD =
    TIMEOUT_EN ? TIMER_W'(TIMEOUT_CYCLES - 1) : TIMER_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [TIMER_W-1:0]   timer_r;
  logic [TIMER_W-1:0]   timer_nxt_s;
  logic                 menu_d_r;
  logic                 menu_rise_s;
  logic                 mode_ok_s;
  logic                 timeout_nxt_s;
  logic [NUM_KEYS-1:0]  onehot_cap_s;
  logic [IDX_W-1:0]     index_cap_s;
  logic                 req_valid_r;
  logic [NUM_KEYS-1:0]  req_onehot_r;
  logic [IDX_W-1:0]     req_index_r;
  logic                 armed_r;
  logic                 timeout_pulse_r;

  // Isolate the lowest set key: bit0 has the highest priority.
  function automatic logic [NUM_KEYS-1:0] lowest_onehot(input logic [NUM_KEYS-1:0] keys);
    return keys & (~keys + NUM_KEYS'(1));
  endfunction

  // Binary index of the lowest set key. Scanning downward lets the lowest index win.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] keys);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(0);
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign menu_rise_s = menu_signal & ~menu_d_r;
  assign mode_ok_s   = (current_mode == ARM_MODE);

  // Next-state, timer and capture logic. A mode exit aborts ahead of every other event.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    onehot_cap_s  = req_onehot_r;
    index_cap_s   = req_index_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mode_ok_s && menu_rise_s) begin
          state_nxt_s = ST_ARMED;
          timer_nxt_s = RELOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!mode_ok_s) begin
          state_nxt_s = ST_IDLE;
        end else if (menu_rise_s) begin
          timer_nxt_s = RELOAD;
        end else if (menu_signal) begin
          // Menu still held: freeze the window and ignore keys until release.
          timer_nxt_s = timer_r;
        end else if (|key_in) begin
          state_nxt_s  = ST_REQ;
          onehot_cap_s = lowest_onehot(key_in);
          index_cap_s  = lowest_index(key_in);
        end else if (TIMEOUT_EN && (timer_r == TIMER_W'(0))) begin
          state_nxt_s   = ST_IDLE;
          timeout_nxt_s = 1'b1;
        end else if (TIMEOUT_EN) begin
          // This branch is only reached with timer_r nonzero, so no underflow.
          timer_nxt_s = timer_r - TIMER_W'(1);
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      ST_REQ: begin
        if (!mode_ok_s) begin
          state_nxt_s = ST_IDLE;
        end else if (req_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, timer and menu-history registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      timer_r  <= TIMER_W'(0);
      menu_d_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      menu_d_r <= menu_signal;
    end
  end

  // Output registers. Each output is decoded from the next state so it lines up with state_r.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_valid_r     <= 1'b0;
      req_onehot_r    <= NUM_KEYS'(0);
      req_index_r     <= IDX_W'(0);
      armed_r         <= 1'b0;
      timeout_pulse_r <= 1'b0;
    end else begin
      req_valid_r     <= (state_nxt_s == ST_REQ);
      req_onehot_r    <= (state_nxt_s == ST_REQ) ? onehot_cap_s : NUM_KEYS'(0);
      req_index_r     <= (state_nxt_s == ST_REQ) ? index_cap_s : IDX_W'(0);
      armed_r         <= (state_nxt_s == ST_ARMED);
      timeout_pulse_r <= timeout_nxt_s;
    end
  end

  assign req_valid     = req_valid_r;
  assign req_onehot    = req_onehot_r;
  assign req_index     = req_index_r;
  assign armed         = armed_r;
  assign timeout_pulse = timeout_pulse_r;

endmodule

// File: tb/tb_menu_key_sequence_decoder.sv
// Directed bench for menu_key_sequence_decoder.
// DUT a uses 4 keys with an 8-cycle timeout. DUT b uses 1 key and never times out.
module tb_menu_key_sequence_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [2:0] mode_a;
  logic       menu_a;
  logic [3:0] keys_a;
  logic       ack_a;
  logic       valid_a;
  logic [3:0] onehot_a;
  logic [1:0] idx_a;
  logic       armed_a;
  logic       pulse_a;

  logic [2:0] mode_b;
  logic       menu_b;
  logic [0:0] keys_b;
  logic       ack_b;
  logic       valid_b;
  logic [0:0] onehot_b;
  logic [0:0] idx_b;
  logic       armed_b;
  logic       pulse_b;

  menu_key_sequence_decoder #(
    .NUM_KEYS(4), .MODE_W(3), .ARM_MODE(3'd0), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rstn(rstn), .current_mode(mode_a), .menu_signal(menu_a),
    .key_in(keys_a), .req_ack(ack_a), .req_valid(valid_a), .req_onehot(onehot_a),
    .req_index(idx_a), .armed(armed_a), .timeout_pulse(pulse_a)
  );

  menu_key_sequence_decoder #(
    .NUM_KEYS(1), .MODE_W(3), .ARM_MODE(3'd0), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rstn(rstn), .current_mode(mode_b), .menu_signal(menu_b),
    .key_in(keys_b), .req_ack(ack_b), .req_valid(valid_b), .req_onehot(onehot_b),
    .req_index(idx_b), .armed(armed_b), .timeout_pulse(pulse_b)
  );

  // Observed outputs packed as {valid, onehot, index, armed, pulse}.
  logic [8:0] obs_a;
  logic [4:0] obs_b;
  assign obs_a = {valid_a, onehot_a, idx_a, armed_a, pulse_a};
  assign obs_b = {valid_b, onehot_b, idx_b, armed_b, pulse_b};

  localparam logic [8:0] A_IDLE  = 9'b0_0000_00_0_0;
  localparam logic [8:0] A_ARMED = 9'b0_0000_00_1_0;
  localparam logic [4:0] B_IDLE  = 5'b0_0_0_0_0;
  localparam logic [4:0] B_ARMED = 5'b0_0_0_1_0;
  localparam logic [4:0] B_REQ   = 5'b1_1_0_0_0;

  typedef struct {
    logic [2:0] mode;
    logic       menu;
    logic [3:0] keys;
    logic       ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [2:0] m, input logic mn, input logic [3:0] k,
                              input logic a, input logic [8:0] e);
    vec_t v;
    v.mode = m;
    v.menu = mn;
    v.keys = k;
    v.ack  = a;
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn   = 1'b0;
    mode_a = 3'd0; menu_a = 1'b0; keys_a = 4'b0000; ack_a = 1'b0;
    mode_b = 3'd0; menu_b = 1'b0; keys_b = 1'b0;    ack_b = 1'b0;

    // Cycle-by-cycle vectors: inputs for one cycle, then the outputs after that edge.
    // Basic capture of key 2, then ack.
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b0, 4'b0100, 1'b0, 9'b1_0100_10_0_0));
    vq.push_back(mk(3'd0, 1'b0, 4'b0000, 1'b1, A_IDLE));
    // Priority: keys ignored while menu held, then the lowest set index wins.
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b1, 4'b1010, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b0, 4'b1010, 1'b0, 9'b1_0010_01_0_0));
    vq.push_back(mk(3'd0, 1'b0, 4'b0001, 1'b0, 9'b1_0010_01_0_0));
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, 9'b1_0010_01_0_0));
    vq.push_back(mk(3'd0, 1'b0, 4'b0000, 1'b1, A_IDLE));
    vq.push_back(mk(3'd0, 1'b0, 4'b0000, 1'b1, A_IDLE));
    // Mode gating: a rise outside ARM_MODE is lost. A held level does not arm later.
    vq.push_back(mk(3'd2, 1'b1, 4'b0000, 1'b0, A_IDLE));
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_IDLE));
    vq.push_back(mk(3'd0, 1'b0, 4'b0000, 1'b0, A_IDLE));
    // Abort from ARMED.
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b0, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd1, 1'b0, 4'b0000, 1'b0, A_IDLE));
    // Abort from REQ, even with ack present.
    vq.push_back(mk(3'd0, 1'b1, 4'b0000, 1'b0, A_ARMED));
    vq.push_back(mk(3'd0, 1'b0, 4'b1000, 1'b0, 9'b1_1000_11_0_0));
    vq.push_back(mk(3'd5, 1'b0, 4'b0000, 1'b1, A_IDLE));
    vq.push_back(mk(3'd0, 1'b0, 4'b0000, 1'b0, A_IDLE));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", obs_a, A_IDLE);
    chk("reset_b", obs_b, B_IDLE);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      mode_a = vq[i].mode;
      menu_a = vq[i].menu;
      keys_a = vq[i].keys;
      ack_a  = vq[i].ack;
      tick();
      chk($sformatf("vec%0d", i), obs_a, vq[i].exp);
    end
    mode_a = 3'd0; menu_a = 1'b0; keys_a = 4'b0000; ack_a = 1'b0;

    // Timeout: 8 armed cycles, then a single pulse.
    menu_a = 1'b1;
    tick();
    chk("to_arm", obs_a, A_ARMED);
    menu_a = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), obs_a, A_ARMED);
    end
    tick();
    chk("to_expire", obs_a, 9'b0_0000_00_0_1);
    tick();
    chk("to_pulse_once", obs_a, A_IDLE);

    // A key on the expiry cycle wins, and no pulse fires.
    menu_a = 1'b1;
    tick();
    menu_a = 1'b0;
    repeat (7) tick();
    chk("exp_still_armed", obs_a, A_ARMED);
    keys_a = 4'b0001;
    tick();
    chk("key_at_expiry", obs_a, 9'b1_0001_00_0_0);
    keys_a = 4'b0000;
    ack_a  = 1'b1;
    tick();
    chk("key_at_expiry_ack", obs_a, A_IDLE);
    ack_a = 1'b0;

    // Re-arm when the timer reaches 2 reloads the full window.
    menu_a = 1'b1;
    tick();
    menu_a = 1'b0;
    repeat (5) tick();
    menu_a = 1'b1;
    tick();
    chk("rearm", obs_a, A_ARMED);
    menu_a = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("rearm_hold%0d", i), obs_a, A_ARMED);
    end
    tick();
    chk("rearm_expire", obs_a, 9'b0_0000_00_0_1);

    // Async reset mid-request, then a rise against the cleared menu history.
    menu_a = 1'b1;
    tick();
    menu_a = 1'b0;
    keys_a = 4'b0100;
    tick();
    chk("pre_reset_req", obs_a, 9'b1_0100_10_0_0);
    keys_a = 4'b0000;
    #3;
    rstn = 1'b0;
    #1;
    chk("async_reset_a", obs_a, A_IDLE);
    menu_a = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_reset_arm", obs_a, A_ARMED);
    menu_a = 1'b0;
    mode_a = 3'd1;
    tick();
    chk("post_reset_abort", obs_a, A_IDLE);
    mode_a = 3'd0;

    // Single-key instance without a timeout.
    menu_b = 1'b1;
    tick();
    chk("b_arm", obs_b, B_ARMED);
    menu_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("b_no_timeout%0d", i), obs_b, B_ARMED);
    end
    keys_b = 1'b1;
    tick();
    chk("b_req", obs_b, B_REQ);
    keys_b = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    chk("b_async_reset", obs_b, B_IDLE);
    menu_b = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    chk("b_post_reset_arm", obs_b, B_ARMED);
    menu_b = 1'b0;
    keys_b = 1'b1;
    tick();
    chk("b_req2", obs_b, B_REQ);
    keys_b = 1'b0;
    ack_b  = 1'b1;
    tick();
    chk("b_ack", obs_b, B_IDLE);
    ack_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
